// File: rtl/seg595_pkg.sv
// Shared definitions for the 74HC595 display serialiser: frame geometry,
// controller state encoding and active-low seven-segment patterns.
// Imported by seg595_clk_div and seg_595_ctrl.
package seg595_pkg;

   localparam int SEL_W   = 6;
   localparam int SEG_W   = 8;
   localparam int FRAME_W = SEG_W + SEL_W;   // 14, fixed by the board wiring

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Segments are active-low: a 1 turns the segment off.
   localparam logic [SEG_W-1:0] SEG_BLANK = 8'hff;

   function automatic logic [SEG_W-1:0] seg_digit(input logic [3:0] d);
      logic [SEG_W-1:0] pat;
      case (d)
         4'd0:    pat = 8'hc0;
         4'd1:    pat = 8'hf9;
         4'd2:    pat = 8'ha4;
         4'd3:    pat = 8'hb0;
         4'd4:    pat = 8'h99;
         4'd5:    pat = 8'h92;
         4'd6:    pat = 8'h82;
         4'd7:    pat = 8'hf8;
         4'd8:    pat = 8'h80;
         4'd9:    pat = 8'h90;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg595_clk_div.sv
// Shift-clock divider: splits each bit into a low and a high shcp phase of CLK_DIV/2 cycles.
// Latency: strobes are combinational from the phase counter; counter restarts the cycle after run rises.
// Backpressure: none; counts freely while run is high, held at zero while run is low.
// Ports: clk, rst (sync, active-high), run (frame in flight),
//        shcp_hi (current cycle is in the high phase), shcp_rise_en (last low-phase cycle),
//        bit_end_en (last cycle of a bit).
module seg595_clk_div
   import seg595_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic shcp_hi,
   output logic shcp_rise_en,
   output logic bit_end_en
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign shcp_hi      = run && (cnt >= HALF);
   assign shcp_rise_en = run && (cnt == HALF_M1);
   assign bit_end_en   = run && (cnt == LAST);

endmodule

// File: rtl/seg_595_ctrl.sv
// Serialises {seg, sel} MSB-first into two cascaded 74HC595s, then pulses the storage clock.
// Latency: every pin is registered one cycle behind the FSM; frame period 1 + 14*CLK_DIV + CLK_DIV/2.
// Backpressure: none; inputs are snapshotted in IDLE and ignored until the next IDLE.
// Ports: sys_clk, sys_rst (sync, active-high), sel[5:0], seg[7:0] (active-low segments),
//        ds/shcp/stcp/oe (595 pins, oe active-low), busy, frame_done (one-cycle pulse).
// Build option: SEG595_CHANGE_ONLY_EN holds IDLE until {seg, sel} differs from the last frame sent.
module seg_595_ctrl
   import seg595_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [SEL_W-1:0] sel,
   input  logic [SEG_W-1:0] seg,
   output logic             ds,
   output logic             shcp,
   output logic             stcp,
   output logic             oe,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

   state_t             state, state_n;
   logic [FRAME_W-1:0] shreg, shreg_n;
   logic [3:0]         bit_cnt, bit_cnt_n;
   logic               start;
   logic               shcp_hi, shcp_rise_en, bit_end_en;
   logic               ds_d, shcp_d, stcp_d, busy_d, done_d;

   seg595_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk          (sys_clk),
      .rst          (sys_rst),
      .run          (state != IDLE),
      .shcp_hi      (shcp_hi),
      .shcp_rise_en (shcp_rise_en),
      .bit_end_en   (bit_end_en)
   );

`ifdef SEG595_CHANGE_ONLY_EN
   logic [FRAME_W-1:0] last_frame;
   logic               have_last;

   // Record each snapshot as it is taken; a reset forgets it so the first
   // frame afterwards always goes out.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         have_last  <= 1'b0;
         last_frame <= '0;
      end else if (state == IDLE && start) begin
         have_last  <= 1'b1;
         last_frame <= {seg, sel};
      end
   end

   assign start = !have_last || ({seg, sel} != last_frame);
`else
   assign start = 1'b1;
`endif

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      ds_d      = 1'b0;
      shcp_d    = 1'b0;
      stcp_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (start) begin
               shreg_n = {seg, sel};
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            ds_d   = shreg[FRAME_W-1];
            shcp_d = shcp_hi;
            if (bit_end_en) begin
               shreg_n = {shreg[FRAME_W-2:0], 1'b0};
               if (bit_cnt == LAST_BIT) begin
                  state_n = LATCH;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         LATCH: begin
            busy_d = 1'b1;
            stcp_d = 1'b1;
            ds_d   = ds;   // hold the last data bit through the latch pulse
            // The divider restarts at the LATCH entry, so its half-period
            // strobe marks the last of the CLK_DIV/2 latch cycles.
            if (shcp_rise_en) begin
               done_d  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         ds         <= 1'b0;
         shcp       <= 1'b0;
         stcp       <= 1'b0;
         oe         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         ds         <= ds_d;
         shcp       <= shcp_d;
         stcp       <= stcp_d;
         busy       <= busy_d;
         frame_done <= done_d;
         // Outputs stay blanked until a complete frame has been latched.
         oe         <= oe & ~done_d;
      end
   end

endmodule

// File: tb/tb_seg_595_ctrl.sv
// Self-checking bench for seg_595_ctrl: a CLK_DIV=4 and a CLK_DIV=8 instance share
// stimulus; a frame-level reference model predicts every pin every cycle, and
// directed sequences cover reset, mid-frame changes and mid-frame reset.
module tb_seg_595_ctrl;

`ifdef SEG595_CHANGE_ONLY_EN
   localparam bit CHG_ONLY = 1'b1;
`else
   localparam bit CHG_ONLY = 1'b0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [5:0] sel     = 6'h3f;
   logic [7:0] seg     = 8'hc0;
   logic ds4, shcp4, stcp4, oe4, busy4, done4;
   logic ds8, shcp8, stcp8, oe8, busy8, done8;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;
   int overlap = 0;

   always #5 sys_clk = ~sys_clk;

   seg_595_ctrl #(.CLK_DIV(4)) dut4 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sel(sel), .seg(seg),
      .ds(ds4), .shcp(shcp4), .stcp(stcp4), .oe(oe4), .busy(busy4), .frame_done(done4)
   );

   seg_595_ctrl #(.CLK_DIV(8)) dut8 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sel(sel), .seg(seg),
      .ds(ds8), .shcp(shcp8), .stcp(stcp8), .oe(oe8), .busy(busy8), .frame_done(done8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A frame is an idle slot (offset 0), 14 bits of D cycles each, then D/2
   // latch cycles. Pins appear one cycle after the slot they describe, so the
   // model computes, at each edge, the slot that edge closes.
   // Vector order: {ds, shcp, stcp, oe, busy, frame_done}.
   int         pos  [2] = '{0, 0};
   logic [13:0] fr  [2] = '{14'd0, 14'd0};
   logic [13:0] lastf[2] = '{14'd0, 14'd0};
   bit         have [2] = '{1'b0, 1'b0};
   logic       oem  [2] = '{1'b1, 1'b1};
   logic [5:0] expv [2] = '{6'b000100, 6'b000100};
   int md, mper, mb, mph;
   logic mdone;

   always @(posedge sys_clk) begin
      for (int i = 0; i < 2; i++) begin
         md   = (i == 0) ? 4 : 8;
         mper = 1 + 14 * md + md / 2;
         if (sys_rst) begin
            pos[i]  = 0;
            oem[i]  = 1'b1;
            have[i] = 1'b0;
            expv[i] = 6'b000100;
         end else if (pos[i] == 0) begin
            expv[i] = {3'b000, oem[i], 2'b00};
            if (!CHG_ONLY || !have[i] || ({seg, sel} != lastf[i])) begin
               fr[i]    = {seg, sel};
               lastf[i] = {seg, sel};
               have[i]  = 1'b1;
               pos[i]   = 1;
            end
         end else if (pos[i] <= 14 * md) begin
            mb  = (pos[i] - 1) / md;
            mph = (pos[i] - 1) % md;
            expv[i] = {fr[i][13 - mb], (mph >= md / 2), 1'b0, oem[i], 1'b1, 1'b0};
            pos[i]  = pos[i] + 1;
         end else begin
            mdone = (pos[i] == mper - 1);
            if (mdone) oem[i] = 1'b0;
            expv[i] = {fr[i][0], 1'b0, 1'b1, oem[i], 1'b1, mdone};
            pos[i]  = mdone ? 0 : pos[i] + 1;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (chk_on) begin
         check("pins_div4", {26'd0, ds4, shcp4, stcp4, oe4, busy4, done4}, {26'd0, expv[0]});
         check("pins_div8", {26'd0, ds8, shcp8, stcp8, oe8, busy8, done8}, {26'd0, expv[1]});
         if ((shcp4 && stcp4) || (shcp8 && stcp8)) overlap++;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Runs until the next frame_done of dut4. Captures ds on each shcp rise.
   // chg_at (>0) swaps seg to chg_seg after that many cycles.
   task automatic collect(input int chg_at, input logic [7:0] chg_seg,
                          output logic [13:0] bits, output int rises,
                          output int stc, output int len, output int oe_early);
      logic prev;
      bits = '0; rises = 0; stc = 0; len = 0; oe_early = 0;
      prev = shcp4;
      do begin
         tick();
         len++;
         if (len == chg_at) seg = chg_seg;
         if (shcp4 && !prev) begin
            bits = {bits[12:0], ds4};
            rises++;
         end
         prev = shcp4;
         if (stcp4) stc++;
         if (!done4 && !oe4) oe_early++;
      end while (!done4 && len < 400);
   endtask

   typedef struct {
      logic [5:0]  sel;
      logic [7:0]  seg;
      logic [13:0] bits;
   } vec_t;

   initial begin
      vec_t tbl [5];
      logic [13:0] bits;
      int rises, stc, len, oe_early, n;

      tbl[0] = '{6'h3f, 8'hc0, 14'b11000000_111111};
      tbl[1] = '{6'h01, 8'hf9, 14'b11111001_000001};
      tbl[2] = '{6'h2a, 8'ha4, 14'b10100100_101010};
      tbl[3] = '{6'h00, 8'hff, 14'b11111111_000000};
      tbl[4] = '{6'h15, 8'h92, 14'b10010010_010101};

      // 1: reset held 5 cycles, then the first frame
      tick();
      chk_on = 1'b1;
      repeat (4) tick();
      check("reset_pins", {26'd0, ds4, shcp4, stcp4, oe4, busy4, done4}, 32'b000100);
      sys_rst = 1'b0;
      collect(0, 8'h00, bits, rises, stc, len, oe_early);
      check("first_done_cycle", len, 59);
      check("first_bits", bits, 14'b11000000_111111);
      check("first_rises", rises, 14);
      check("first_stcp_cycles", stc, 2);
      check("oe_blank_before_done", oe_early, 0);
      check("oe_at_done", oe4, 1'b0);

`ifdef SEG595_CHANGE_ONLY_EN
      // 6: constant input -> no further frames
      n = 0;
      repeat (500) begin
         tick();
         if (busy4) n++;
      end
      check("idle_busy_cycles", n, 0);
      sel = 6'h01;
      n = 0;
      do begin tick(); n++; end while (!busy4 && n < 20);
      check("change_start_delay", n, 2);
      collect(0, 8'h00, bits, rises, stc, len, oe_early);
      check("change_bits", bits, 14'b11000000_000001);
      check("change_rises", rises, 14);
`else
      // 2: continuous refresh with constant input
      collect(0, 8'h00, bits, rises, stc, len, oe_early);
      check("period", len, 59);
      check("period_rises", rises, 14);
      check("period_stcp_cycles", stc, 2);

      // 3: seg changes mid bit 5 -> current frame unaffected, next frame takes it
      collect(23, 8'hf9, bits, rises, stc, len, oe_early);
      check("torn_cur_bits", bits, 14'b11000000_111111);
      collect(0, 8'h00, bits, rises, stc, len, oe_early);
      check("torn_next_bits", bits, 14'b11111001_111111);

      // 4: one-cycle reset during bit 9
      repeat (39) tick();
      sys_rst = 1'b1;
      tick();
      check("midreset_pins", {26'd0, ds4, shcp4, stcp4, oe4, busy4, done4}, 32'b000100);
      sys_rst = 1'b0;
      collect(0, 8'h00, bits, rises, stc, len, oe_early);
      check("after_reset_len", len, 59);
      check("after_reset_bits", bits, 14'b11111001_111111);
      check("after_reset_oe_blank", oe_early, 0);

      // table-driven frames
      for (int i = 0; i < 5; i++) begin
         sel = tbl[i].sel;
         seg = tbl[i].seg;
         collect(0, 8'h00, bits, rises, stc, len, oe_early);
         check($sformatf("tbl%0d_bits", i), bits, tbl[i].bits);
         check($sformatf("tbl%0d_len", i), len, 59);
      end

      // 5: CLK_DIV=8 frame period
      n = 0;
      do begin tick(); n++; end while (!done8 && n < 300);
      n = 0;
      do begin tick(); n++; end while (!done8 && n < 300);
      check("div8_period", n, 117);
`endif

      // randomized input changes and occasional resets, checked by the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) begin
            sel = 6'($urandom);
            seg = 8'($urandom);
         end
         sys_rst = ($urandom_range(0, 499) == 0);
         tick();
      end
      sys_rst = 1'b0;
      repeat (3) tick();

      check("shcp_stcp_overlap", overlap, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
